// File: rtl/riscv_bp_gshare.sv
// riscv_bp_gshare: gshare direction predictor, 2-bit saturating counters indexed by {history, pc}.
// After reset the table is swept to weakly not-taken before predictions are enabled.
`default_nettype none

module riscv_bp_gshare #(
  parameter int XLEN           = 32,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int BP_LOCAL_BITS  = 10,
  parameter int HAS_RVC        = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      if_stall,
  input  logic [XLEN-1:0]           if_parcel_pc,
  input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history,
  input  logic [XLEN-1:0]           ex_pc,
  input  logic                      bu_bp_update,
  input  logic                      bu_bp_btaken,
  input  logic [1:0]                bu_bp_predict,
  output logic [1:0]                bp_bp_predict,
  output logic                      bp_ready
);

  localparam int IDX   = BP_GLOBAL_BITS + BP_LOCAL_BITS;
  localparam int DEPTH = 1 << IDX;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [IDX-1:0]           r_sweep, w_sweep_nxt;
  logic [1:0]               r_table [DEPTH];
  logic [1:0]               r_pred;
  logic [BP_LOCAL_BITS-1:0] w_rd_slice, w_wr_slice;
  logic [IDX-1:0]           w_rd_idx, w_wr_idx, w_waddr;
  logic [1:0]               w_upd_val, w_wdata;
  logic                     w_we, w_bypass;

  generate
    if (HAS_RVC != 0) begin : g_rvc
      assign w_rd_slice = if_parcel_pc[BP_LOCAL_BITS:1];
      assign w_wr_slice = ex_pc[BP_LOCAL_BITS:1];
    end else begin : g_norvc
      assign w_rd_slice = if_parcel_pc[BP_LOCAL_BITS+1:2];
      assign w_wr_slice = ex_pc[BP_LOCAL_BITS+1:2];
    end
  endgenerate

  // Only the index slice of each PC is consumed.
  logic w_unused_pc;
  assign w_unused_pc = &{1'b0, if_parcel_pc, ex_pc};

  assign w_rd_idx = {bu_bp_history, w_rd_slice};
  assign w_wr_idx = {bu_bp_history, w_wr_slice};

  // New counter comes from the value carried down the pipe, not a table re-read.
  always_comb begin
    w_upd_val = bu_bp_predict;
    if (bu_bp_btaken) begin
      if (bu_bp_predict != 2'b11) w_upd_val = bu_bp_predict + 2'b01;
    end else begin
      if (bu_bp_predict != 2'b00) w_upd_val = bu_bp_predict - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_sweep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    w_we        = 1'b0;
    w_waddr     = w_wr_idx;
    w_wdata     = w_upd_val;
    case (r_state)
      S_INIT: begin
        w_we        = 1'b1;
        w_waddr     = r_sweep;
        w_wdata     = 2'b01;
        w_sweep_nxt = r_sweep + IDX'(1);
        if (r_sweep == IDX'(DEPTH - 1)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_we = bu_bp_update;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) r_table[w_waddr] <= w_wdata;
  end

  assign w_bypass = (r_state == S_RUN) && bu_bp_update && (w_wr_idx == w_rd_idx);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pred <= 2'b00;
    end else if (r_state != S_RUN) begin
      r_pred <= 2'b00;
    end else if (!if_stall) begin
      r_pred <= w_bypass ? w_upd_val : r_table[w_rd_idx];
    end
  end

  assign bp_bp_predict = r_pred;
  assign bp_ready      = (r_state == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_riscv_bp_gshare.sv
// Directed bench for riscv_bp_gshare with a 64-entry table (2 history bits, 4 PC bits).
`default_nettype none

module tb_riscv_bp_gshare;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_stall;
  logic [31:0] if_parcel_pc;
  logic [1:0]  bu_bp_history;
  logic [31:0] ex_pc;
  logic        bu_bp_update;
  logic        bu_bp_btaken;
  logic [1:0]  bu_bp_predict;
  logic [1:0]  bp_bp_predict;
  logic        bp_ready;

  int n_checks = 0;
  int n_errors = 0;
  int cnt;

  always #5 clk = ~clk;

  riscv_bp_gshare #(
    .XLEN(32), .BP_GLOBAL_BITS(2), .BP_LOCAL_BITS(4), .HAS_RVC(0)
  ) dut (
    .clk(clk), .rstn(rstn), .if_stall(if_stall), .if_parcel_pc(if_parcel_pc),
    .bu_bp_history(bu_bp_history), .ex_pc(ex_pc), .bu_bp_update(bu_bp_update),
    .bu_bp_btaken(bu_bp_btaken), .bu_bp_predict(bu_bp_predict),
    .bp_bp_predict(bp_bp_predict), .bp_ready(bp_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with an update at ex_pc while fetch reads rd_pc; both share the history.
  task automatic upd(input logic [1:0] hist, input logic [31:0] e_pc, input logic [31:0] rd_pc,
                     input logic taken, input logic [1:0] old);
    bu_bp_history = hist; ex_pc = e_pc; if_parcel_pc = rd_pc;
    bu_bp_btaken = taken; bu_bp_predict = old; bu_bp_update = 1'b1;
    tick();
    bu_bp_update = 1'b0;
  endtask

  task automatic rd(input logic [1:0] hist, input logic [31:0] pc);
    bu_bp_history = hist; if_parcel_pc = pc;
    tick();
  endtask

  initial begin
    rstn = 1'b0; if_stall = 1'b0; if_parcel_pc = '0; bu_bp_history = '0;
    ex_pc = '0; bu_bp_update = 1'b0; bu_bp_btaken = 1'b0; bu_bp_predict = '0;
    repeat (3) tick();
    check("rst_ready", {31'd0, bp_ready}, 32'd0);
    check("rst_pred", {30'd0, bp_bp_predict}, 32'd0);

    rstn = 1'b1;
    cnt = 0;
    while (!bp_ready && cnt < 200) begin
      tick();
      cnt++;
      if (cnt == 10) check("init_pred", {30'd0, bp_bp_predict}, 32'd0);
    end
    check("init_len", cnt, 64);

    rd(2'b11, 32'h3C);
    check("first_pred", {30'd0, bp_bp_predict}, 32'd1);

    rd(2'b10, 32'h14);
    check("rd_14", {30'd0, bp_bp_predict}, 32'd1);
    upd(2'b10, 32'h14, 32'h18, 1'b1, 2'b01);
    check("rd_18", {30'd0, bp_bp_predict}, 32'd1);
    rd(2'b10, 32'h14);
    check("rerd_14", {30'd0, bp_bp_predict}, 32'd2);

    upd(2'b00, 32'h24, 32'h00, 1'b1, 2'b11);
    rd(2'b00, 32'h24);
    check("sat_hi", {30'd0, bp_bp_predict}, 32'd3);
    upd(2'b00, 32'h28, 32'h00, 1'b0, 2'b00);
    rd(2'b00, 32'h28);
    check("sat_lo", {30'd0, bp_bp_predict}, 32'd0);
    upd(2'b00, 32'h24, 32'h00, 1'b0, 2'b10);
    rd(2'b00, 32'h24);
    check("dec_10", {30'd0, bp_bp_predict}, 32'd1);
    upd(2'b00, 32'h30, 32'h00, 1'b0, 2'b01);
    rd(2'b00, 32'h30);
    check("dec_01", {30'd0, bp_bp_predict}, 32'd0);

    upd(2'b01, 32'h20, 32'h20, 1'b1, 2'b10);
    check("collide", {30'd0, bp_bp_predict}, 32'd3);

    rd(2'b00, 32'h28);
    check("pre_stall", {30'd0, bp_bp_predict}, 32'd0);
    if_stall = 1'b1;
    rd(2'b00, 32'h24);
    check("stall_1", {30'd0, bp_bp_predict}, 32'd0);
    upd(2'b00, 32'h3C, 32'h2C, 1'b1, 2'b01);
    check("stall_2", {30'd0, bp_bp_predict}, 32'd0);
    rd(2'b00, 32'h3C);
    check("stall_3", {30'd0, bp_bp_predict}, 32'd0);
    if_stall = 1'b0;
    rd(2'b00, 32'h3C);
    check("post_stall", {30'd0, bp_bp_predict}, 32'd2);

    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (30) tick();
    rstn = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, bp_ready}, 32'd0);
    check("mid_rst_pred", {30'd0, bp_bp_predict}, 32'd0);
    tick();
    rstn = 1'b1;
    bu_bp_history = 2'b10; ex_pc = 32'h14; bu_bp_btaken = 1'b1; bu_bp_predict = 2'b11;
    cnt = 0;
    while (!bp_ready && cnt < 200) begin
      bu_bp_update = (cnt == 50);
      tick();
      cnt++;
    end
    bu_bp_update = 1'b0;
    check("reinit_len", cnt, 64);
    rd(2'b10, 32'h14);
    check("init_upd_ign", {30'd0, bp_bp_predict}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_bp_gshare.md
Name: riscv_bp_gshare

Overview:
Gshare branch predictor feeding the fetch stage and consuming the resolution results from the EX-stage branch unit. It holds a table of 2-bit saturating counters indexed by global history concatenated with fetch-PC bits. It returns a registered prediction one cycle after the fetch address is presented, and updates the table from the branch unit's btaken/update/history outputs. A post-reset sweep initialises the table before predictions are enabled.

Parameters:
XLEN, 32, address width
BP_GLOBAL_BITS, 2, global history bits in the index
BP_LOCAL_BITS, 10, PC bits in the index
HAS_RVC, 0, nonzero selects PC bits starting at bit 1 instead of bit 2

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
if_stall  input  1  fetch stall; hold the read index and the prediction output
if_parcel_pc  input  XLEN  fetch address to predict
bu_bp_history  input  BP_GLOBAL_BITS  global history from the branch unit, used for read and write index
ex_pc  input  XLEN  PC of the branch currently resolved by the branch unit
bu_bp_update  input  1  write the table this cycle
bu_bp_btaken  input  1  resolved direction
bu_bp_predict  input  2  counter value read at prediction time, carried down the pipe
bp_bp_predict  output  2  predicted counter; bit1=1 means predict taken
bp_ready  output  1  table initialised, predictions valid

Behaviour:
- Reset: rstn is asynchronous and active-low; clock is clk. Asynchronous assertion gives bp_bp_predict=2'b00, bp_ready=0, FSM=INIT, sweep counter=0.
- IDX = BP_GLOBAL_BITS+BP_LOCAL_BITS; the table has 2^IDX entries of 2 bits each.
- PC slice: HAS_RVC ? pc[BP_LOCAL_BITS:1] : pc[BP_LOCAL_BITS+1:2].
- Read index = {bu_bp_history, slice(if_parcel_pc)}.
- Write index = {bu_bp_history, slice(ex_pc)}.
- FSM states and transitions:
  - INIT: each cycle writes 2'b01 (weakly not-taken) to entry[sweep] and increments sweep.
  - INIT exits to RUN on the cycle sweep==2^IDX-1 is written.
  - RUN: bp_ready=1 from the first RUN cycle; no exit except reset.
  - Reset asserted mid-INIT or in RUN restarts INIT from entry 0.
- INIT outputs: bp_bp_predict is forced to 2'b00 and bu_bp_update is ignored; lost updates are acceptable.
- Read latency (RUN): on a clk edge with !if_stall, bp_bp_predict <= entry[read index]. The value appears 1 cycle after if_parcel_pc is presented.
- if_stall=1: bp_bp_predict holds its value; the table still accepts updates.
- Update (RUN, bu_bp_update=1), new value derived from bu_bp_predict with no read-modify-write:
  - btaken=1: 2'b11 if old==2'b11, else old+1.
  - btaken=0: 2'b00 if old==2'b00, else old-1.
  - The write commits at the clk edge.
- Read/write collision: same index, same cycle, !if_stall. The read returns the newly written value (write-first bypass).
- Back-to-back updates to the same index: each uses its own bu_bp_predict. The last write wins; no merge.
- All counter arithmetic is 2-bit and never wraps; saturation is mandatory.
- Index arithmetic is unsigned; history bits are the MSBs of the index.
- Storage is a synchronous-read array, mappable to a single-port-read/single-port-write RAM.

Test Plan (BP_GLOBAL_BITS=2, BP_LOCAL_BITS=4, HAS_RVC=0, 64 entries):
- Release rstn, no stimulus -> bp_ready=0 for exactly 64 cycles, then 1. The first prediction after ready for any pc/history reads 2'b01.
- RUN, history=2'b10, if_parcel_pc=0x0000_0014 -> bp_bp_predict=2'b01 one cycle later. Then update ex_pc=0x14, history=2'b10, btaken=1, bu_bp_predict=2'b01 -> re-read gives 2'b10.
- Saturation:
  - bu_bp_predict=2'b11, btaken=1 -> entry reads 2'b11.
  - bu_bp_predict=2'b00, btaken=0 -> entry reads 2'b00.
  - bu_bp_predict=2'b10, btaken=0 -> entry reads 2'b01.
- Collision: same cycle, read and write index both {2'b01, pc 0x20}, update btaken=1 with old=2'b10 -> bp_bp_predict=2'b11 next cycle.
- if_stall=1 for 3 cycles while if_parcel_pc changes -> bp_bp_predict unchanged. An update applied during the stall is visible on the first read after the stall.
- Assert rstn low at sweep entry 30 in INIT, then release -> bp_ready low for a full 64 cycles. A bu_bp_update during INIT has no effect; the entry reads 2'b01.
